// File: rtl/seq_controller.sv
// rtl/seq_controller.sv - up/down ramp sequencer driving an external 4-bit counter
module seq_controller #(
  parameter int MAX_COUNT   = 15,
  parameter int HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       progressive,
  input  logic       regressive,
  input  logic [3:0] count,
  output logic       cnt_enable,
  output logic       cnt_forward,
  output logic       cnt_reset,
  output logic [1:0] color,
  output logic [2:0] state,
  output logic       done,
  output logic       hold_ready,
  output logic [7:0] laps
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_UP    = 3'd2;
  localparam logic [2:0] S_DOWN  = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;

  localparam logic [3:0] MAX_CNT  = 4'(MAX_COUNT);
  localparam logic [7:0] HOLD_LIM = 8'(HOLD_CYCLES);

  logic [2:0] next_state;
  logic       start_q;
  logic       prog_q;
  logic       regr_q;
  logic [7:0] dwell;
  logic       start_edge;
  logic       prog_edge;
  logic       regr_edge;

  assign start_edge = start & ~start_q;
  assign prog_edge  = progressive & ~prog_q;
  assign regr_edge  = regressive & ~regr_q;

  // Edge registers track inputs even in reset so release never sees a false edge.
  always_ff @(posedge clk) begin
    start_q <= start;
    prog_q  <= progressive;
    regr_q  <= regressive;
    if (reset) begin
      state <= S_IDLE;
      laps  <= 8'd0;
      dwell <= 8'd0;
    end else begin
      state <= next_state;
      if (state == S_DOWN && next_state == S_HOLD && laps != 8'hFF) begin
        laps <= laps + 8'd1;
      end
      if (state != S_HOLD) begin
        dwell <= 8'd0;
      end else if (dwell != HOLD_LIM) begin
        dwell <= dwell + 8'd1;
      end
    end
  end

  always_comb begin
    next_state = S_IDLE;
    case (state)
      S_IDLE:  next_state = start_edge ? S_CLEAR : S_IDLE;
      S_CLEAR: next_state = S_UP;
      S_UP:    next_state = (count >= MAX_CNT) ? S_DOWN : S_UP;
      S_DOWN:  next_state = (count == 4'd0) ? S_HOLD : S_DOWN;
      S_HOLD: begin
        next_state = S_HOLD;
        if (hold_ready) begin
          if (prog_edge) begin
            next_state = S_UP;
          end else if (regr_edge) begin
            next_state = S_IDLE;
          end
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  assign hold_ready = (state == S_HOLD) && (dwell == HOLD_LIM);

  always_comb begin
    color       = 2'b01;
    cnt_enable  = 1'b0;
    cnt_forward = 1'b1;
    cnt_reset   = 1'b0;
    case (state)
      S_CLEAR: begin
        color     = 2'b10;
        cnt_reset = 1'b1;
      end
      S_UP: begin
        color      = 2'b10;
        cnt_enable = (count < MAX_CNT);
      end
      S_DOWN: begin
        color       = 2'b10;
        cnt_forward = 1'b0;
        cnt_enable  = (count != 4'd0);
      end
      S_HOLD: begin
        color       = 2'b11;
        cnt_forward = 1'b0;
      end
      default: begin
        color = 2'b01;
      end
    endcase
    // Reset clears the external counter while it is asserted, whatever the state.
    if (reset) begin
      cnt_reset  = 1'b1;
      cnt_enable = 1'b0;
    end
    done = (state == S_HOLD) && (dwell == 8'd0) && !reset;
  end

endmodule

// File: tb/tb_seq_controller.sv
// tb/tb_seq_controller.sv - scoreboard bench for seq_controller with a 4-bit counter model
module tb_seq_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       progressive = 1'b0;
  logic       regressive = 1'b0;
  logic [3:0] cnt = 4'd0;
  logic       cnt_enable;
  logic       cnt_forward;
  logic       cnt_reset;
  logic [1:0] color;
  logic [2:0] state;
  logic       done;
  logic       hold_ready;
  logic [7:0] laps;

  int n_checks = 0;
  int n_errors = 0;
  int wraps = 0;
  int peak = 0;
  int exp_q[$];

  seq_controller #(.MAX_COUNT(15), .HOLD_CYCLES(4)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .progressive(progressive),
    .regressive(regressive),
    .count(cnt),
    .cnt_enable(cnt_enable),
    .cnt_forward(cnt_forward),
    .cnt_reset(cnt_reset),
    .color(color),
    .state(state),
    .done(done),
    .hold_ready(hold_ready),
    .laps(laps)
  );

  initial forever #5 clk = ~clk;

  // External FourBitCounter; any enabled step across 15<->0 is a wrap.
  always @(posedge clk) begin
    if (cnt_reset) begin
      cnt <= 4'd0;
    end else if (cnt_enable) begin
      if ((cnt_forward && cnt == 4'd15) || (!cnt_forward && cnt == 4'd0)) wraps <= wraps + 1;
      cnt <= cnt_forward ? cnt + 4'd1 : cnt - 4'd1;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Each done pulse pops the lap count predicted when its sequence was launched.
  always @(negedge clk) begin
    if (!reset && int'(cnt) > peak) peak = int'(cnt);
    if (!reset && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("done_unexpected", 1, 0);
      end else begin
        check("done_laps", int'(laps), exp_q.pop_front());
      end
      check("done_color", int'(color), 3);
      check("done_count", int'(cnt), 0);
      check("done_peak", peak, 15);
      peak = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_state(input logic [2:0] s, input string tag);
    int n = 0;
    while (state !== s && n < 200) begin
      tick();
      n++;
    end
    check({"reach_", tag}, int'(state), int'(s));
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (hold_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check({"ready_", tag}, int'(hold_ready), 1);
  endtask

  initial begin
    repeat (3) tick();
    check("rst_state", int'(state), 0);
    check("rst_laps", int'(laps), 0);
    check("rst_cnt_reset", int'(cnt_reset), 1);
    check("rst_cnt_enable", int'(cnt_enable), 0);
    check("rst_color", int'(color), 1);
    reset = 1'b0;
    tick();
    check("idle_cnt_reset", int'(cnt_reset), 0);
    check("idle_fwd", int'(cnt_forward), 1);

    // Launch with start held high for the rest of the run.
    start = 1'b1;
    exp_q.push_back(1);
    tick();
    check("clear_state", int'(state), 1);
    check("clear_cnt_reset", int'(cnt_reset), 1);
    check("clear_color", int'(color), 2);
    tick();
    check("up_state", int'(state), 2);
    check("up_enable", int'(cnt_enable), 1);
    check("up_fwd", int'(cnt_forward), 1);
    wait_state(3'd4, "hold1");
    check("hold1_done", int'(done), 1);
    check("hold1_laps", int'(laps), 1);
    check("hold1_ready", int'(hold_ready), 0);
    check("hold1_fwd", int'(cnt_forward), 0);

    // Progressive edge on HOLD cycle 2 is dropped; on cycle 5 it re-runs the ramp.
    tick();
    progressive = 1'b1;
    tick();
    check("prog_early", int'(state), 4);
    check("hold_done_once", int'(done), 0);
    progressive = 1'b0;
    tick();
    tick();
    check("hold_c5_ready", int'(hold_ready), 1);
    progressive = 1'b1;
    exp_q.push_back(2);
    tick();
    check("prog_ok", int'(state), 2);
    check("prog_count", int'(cnt), 0);
    progressive = 1'b0;
    wait_state(3'd4, "hold2");
    wait_ready("hold2");

    progressive = 1'b1;
    regressive = 1'b1;
    exp_q.push_back(3);
    tick();
    check("both_edges", int'(state), 2);
    progressive = 1'b0;
    regressive = 1'b0;
    wait_state(3'd4, "hold3");
    wait_ready("hold3");

    regressive = 1'b1;
    tick();
    check("regr_state", int'(state), 0);
    check("regr_laps", int'(laps), 3);
    check("regr_color", int'(color), 1);
    repeat (3) tick();
    check("no_restart", int'(state), 0);
    regressive = 1'b0;
    start = 1'b0;
    tick();
    start = 1'b1;
    exp_q.push_back(4);
    tick();
    check("restart", int'(state), 1);

    // Abort mid-ramp at count 7; the pending done expectation is withdrawn.
    begin
      int n = 0;
      while (!(state == 3'd2 && cnt == 4'd7) && n < 50) begin
        tick();
        n++;
      end
    end
    check("up_at_7", int'(cnt), 7);
    reset = 1'b1;
    exp_q.delete();
    #1;
    check("rst_mid_cnt_reset", int'(cnt_reset), 1);
    check("rst_mid_enable", int'(cnt_enable), 0);
    tick();
    check("rst_mid_state", int'(state), 0);
    check("rst_mid_laps", int'(laps), 0);
    check("rst_mid_cnt_reset2", int'(cnt_reset), 1);
    check("rst_mid_done", int'(done), 0);
    check("rst_mid_count", int'(cnt), 0);
    reset = 1'b0;
    tick();
    tick();
    check("no_spurious_start", int'(state), 0);

    check("no_wrap", wraps, 0);
    check("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
